// File: rtl/cnn_result_streamer_pkg.sv
// Shared definitions for the convolution result path: feature-map geometry,
// result word format, the stream beat carried between layers, and FSM states.
package cnn_result_streamer_pkg;

  localparam int unsigned IMG_W         = 8;
  localparam int unsigned IMG_H         = 8;
  // A 3x3 valid convolution trims one pixel from every edge.
  localparam int unsigned FMAP_W        = IMG_W - 2;
  localparam int unsigned FMAP_H        = IMG_H - 2;
  localparam int unsigned RESULT_W      = 32;
  localparam int unsigned RESULT_ADDR_W = 6;

  // One word on a result stream; last marks the final word of a frame.
  typedef struct packed {
    logic [RESULT_W-1:0] data;
    logic                last;
  } stream_beat_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StFin
  } streamer_state_e;

  // Raster-order address of (row, col) in a map that is width words wide.
  function automatic int unsigned raster_addr(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned width);
    return row * width + col;
  endfunction

endpackage

// File: rtl/cnn_result_streamer_result_fifo2.sv
// Two-entry synchronous FIFO of stream beats with occupancy output.
// A push and a pop in the same cycle are accepted even when full.
module cnn_result_streamer_result_fifo2
  import cnn_result_streamer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  stream_beat_t push_beat_i,
  input  logic         pop_i,
  output stream_beat_t head_beat_o,
  output logic [1:0]   count_o
);

  stream_beat_t mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push, do_pop;

  assign do_pop      = pop_i && (count_q != 2'd0);
  assign do_push     = push_i && ((count_q != 2'd2) || do_pop);
  assign head_beat_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_beat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/cnn_result_streamer.sv
// Walks the result RAM in raster order after the engine finishes and streams each word out
// on a valid/ready interface with a last flag.
// Optional build macro CNN_RESULT_POOL_EN: 2x2 stride-2 max-pool ahead of the stream.
module cnn_result_streamer
  import cnn_result_streamer_pkg::*;
#(
  parameter int unsigned OUT_W  = FMAP_W,
  parameter int unsigned OUT_H  = FMAP_H,
  parameter int unsigned DATA_W = RESULT_W,
  parameter int unsigned ADDR_W = RESULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o
);

`ifdef CNN_RESULT_POOL_EN
  localparam int unsigned Step = 2;
`else
  localparam int unsigned Step = 1;
`endif
  // Origin of the last window (or last word) in each dimension.
  localparam logic [ADDR_W-1:0] LastCol = ADDR_W'(OUT_W - Step);
  localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(OUT_H - Step);

  streamer_state_e   state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] rd_row, rd_col;
  logic              inflight_q, inflight_last_q;
  logic              issue_last, credit_ok, win_end;
  logic              push, pop;
  logic [1:0]        fifo_count;
  logic [2:0]        credit_sum;
  stream_beat_t      push_beat, head_beat;

  assign m_valid_o = (fifo_count != 2'd0);
  assign pop       = m_valid_o && m_ready_i;
  assign m_data_o  = DATA_W'(head_beat.data);
  assign m_last_o  = m_valid_o && head_beat.last;
  assign rd_addr_o = ADDR_W'(raster_addr(32'(rd_row), 32'(rd_col), OUT_W));

`ifdef CNN_RESULT_POOL_EN
  if ((OUT_W % 2) != 0 || (OUT_H % 2) != 0) begin : gen_odd_fmap
    $error("cnn_result_streamer: OUT_W and OUT_H must be even when pooling");
  end

  logic [1:0]               sub_q, ret_sub_q, open_q;
  logic signed [DATA_W-1:0] max_q, win_max;

  // sub walks (r,c), (r,c+1), (r+1,c), (r+1,c+1) inside the current window.
  assign rd_row  = row_q + ADDR_W'(sub_q[1]);
  assign rd_col  = col_q + ADDR_W'(sub_q[0]);
  assign win_end = (sub_q == 2'd3);
  // A window reserves its FIFO slot when its first read issues; open_q counts reservations.
  assign credit_sum = 3'(fifo_count) + 3'(open_q) - 3'(pop);
  assign credit_ok  = (sub_q != 2'd0) || (credit_sum < 3'd2);
  assign push       = inflight_q && (ret_sub_q == 2'd3);

  // Running signed maximum, restarted by the first word of each window.
  always_comb begin
    win_max = $signed(rd_data_i);
    if ((ret_sub_q != 2'd0) && (max_q > $signed(rd_data_i))) begin
      win_max = max_q;
    end
    push_beat.data = RESULT_W'(win_max);
    push_beat.last = inflight_last_q;
  end

  // Window position of issued and returning reads, slot reservations, running max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q     <= 2'd0;
      ret_sub_q <= 2'd0;
      open_q    <= 2'd0;
      max_q     <= '0;
    end else begin
      if (rd_en_o) begin
        sub_q <= sub_q + 2'd1;
      end
      if (inflight_q) begin
        ret_sub_q <= ret_sub_q + 2'd1;
        max_q     <= win_max;
      end
      open_q <= open_q + {1'b0, rd_en_o && (sub_q == 2'd0)} - {1'b0, push};
    end
  end
`else
  assign rd_row     = row_q;
  assign rd_col     = col_q;
  assign win_end    = 1'b1;
  // A read issues only if its word is guaranteed a FIFO slot when it returns.
  assign credit_sum = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign credit_ok  = (credit_sum < 3'd2);
  assign push       = inflight_q;

  // Returning RAM word goes straight into the FIFO untouched.
  always_comb begin
    push_beat.data = RESULT_W'(rd_data_i);
    push_beat.last = inflight_last_q;
  end
`endif

  // Frame sequencing, read issue and raster pointer advance.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    rd_en_o    = 1'b0;
    issue_last = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        busy_o = 1'b1;
        if (credit_ok) begin
          rd_en_o = 1'b1;
          if (win_end) begin
            if (col_q == LastCol) begin
              col_d = '0;
              if (row_q == LastRow) begin
                row_d      = '0;
                issue_last = 1'b1;
                state_d    = StDrain;
              end else begin
                row_d = row_q + ADDR_W'(Step);
              end
            end else begin
              col_d = col_q + ADDR_W'(Step);
            end
          end
        end
      end
      StDrain: begin
        busy_o = 1'b1;
        if (pop && m_last_o) begin
          state_d = StFin;
        end
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, raster pointer and the one-deep record of the read now returning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      row_q           <= '0;
      col_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_q           <= col_d;
      inflight_q      <= rd_en_o;
      inflight_last_q <= issue_last;
    end
  end

  cnn_result_streamer_result_fifo2 u_result_fifo2 (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_beat_i(push_beat),
    .pop_i      (pop),
    .head_beat_o(head_beat),
    .count_o    (fifo_count)
  );

endmodule
